// File: rtl/seg16_if.sv
// rtl/seg16_if.sv - glyph/brightness inputs and multiplexed display outputs of seg16_scan_mux
// The display stage is the slave; the upstream scroller (or bench) is the master.
interface seg16_if;
  logic [15:0] char_a;
  logic [15:0] char_b;
  logic [15:0] char_c;
  logic [15:0] char_d;
  logic [3:0]  bright;
  logic [15:0] seg_n;
  logic [3:0]  dig_en;
  logic        frame_start;

  modport master (
    output char_a, char_b, char_c, char_d, bright,
    input  seg_n, dig_en, frame_start
  );

  modport slave (
    input  char_a, char_b, char_c, char_d, bright,
    output seg_n, dig_en, frame_start
  );
endinterface

// File: rtl/seg16_scan_mux.sv
// rtl/seg16_scan_mux.sv - four-digit 16-segment scan multiplexer with blanking and PWM
// Glyphs and brightness are shadowed once per frame so a scroll step never tears mid-frame.
module seg16_scan_mux #(
  parameter int DIGIT_TICKS = 3022,
  parameter int BLANK_TICKS = 16
) (
  input  logic    clk,
  input  logic    rst,
  seg16_if.slave  bus
);
  localparam int CW = (DIGIT_TICKS > 1) ? $clog2(DIGIT_TICKS) : 1;
  localparam logic [CW-1:0] SLOT_LAST = CW'(DIGIT_TICKS - 1);
  localparam logic [CW-1:0] BLANK_END = CW'(BLANK_TICKS);

  logic [CW-1:0] slot_cnt;
  logic [1:0]    digit_idx;
  logic [3:0]    pwm_cnt;
  logic [15:0]   glyph_sh [4];
  logic [3:0]    bright_sh;

  logic          frame_edge;
  logic          in_blank;
  logic          lit;

  always_comb begin
    frame_edge = (slot_cnt == '0) && (digit_idx == 2'd0);
    in_blank   = (slot_cnt < BLANK_END);
    lit        = !in_blank && ((bright_sh == 4'hF) || (pwm_cnt < bright_sh));
  end

  // Every output is computed from the current counters, so it trails them by one cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      slot_cnt        <= '0;
      digit_idx       <= 2'd0;
      pwm_cnt         <= 4'd0;
      bright_sh       <= 4'd0;
      for (int i = 0; i < 4; i++) glyph_sh[i] <= 16'hFFFF;
      bus.seg_n       <= 16'hFFFF;
      bus.dig_en      <= 4'b0000;
      bus.frame_start <= 1'b0;
    end else begin
      if (slot_cnt == SLOT_LAST) begin
        slot_cnt  <= '0;
        digit_idx <= digit_idx + 2'd1;
      end else begin
        slot_cnt  <= slot_cnt + 1'b1;
      end

      pwm_cnt <= in_blank ? 4'd0 : pwm_cnt + 4'd1;

      if (frame_edge) begin
        glyph_sh[0] <= bus.char_a;
        glyph_sh[1] <= bus.char_b;
        glyph_sh[2] <= bus.char_c;
        glyph_sh[3] <= bus.char_d;
        bright_sh   <= bus.bright;
      end
      bus.frame_start <= frame_edge;

      if (lit) begin
        bus.seg_n  <= glyph_sh[digit_idx];
        bus.dig_en <= 4'b0001 << digit_idx;
      end else begin
        bus.seg_n  <= 16'hFFFF;
        bus.dig_en <= 4'b0000;
      end
    end
  end
endmodule
